ram_dp_param: RTL and testbench
===============================

RAM_DP_PARAM -- requirements
Module: ram_dp_param

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: address width; DEPTH = 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 8: word width; SHALL be a multiple of 8; NBYTES = DATA_WIDTH/8.
REQ-003 Parameter RDW_MODE, default RDW_READ_FIRST: same-address read/write collision policy (RDW_READ_FIRST or RDW_WRITE_FIRST).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be as follows.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 clr  input  1  request to zero the whole array.
REQ-008 we  input  1  write enable.
REQ-009 waddr  input  ADDR_WIDTH  write address.
REQ-010 wbe  input  NBYTES  byte enables, bit i = data bits [8i+7:8i].
REQ-011 data_in  input  DATA_WIDTH  write data.
REQ-012 re  input  1  read enable.
REQ-013 raddr  input  ADDR_WIDTH  read address.
REQ-014 data_out  output  DATA_WIDTH  registered read data.
REQ-015 rvalid  output  1  data_out updated this cycle.
REQ-016 busy  output  1  clear sweep in progress; accesses are refused.
REQ-017 drop  output  1  one-cycle pulse: a we or re was refused because busy was 1.

Function
REQ-018 The FSM SHALL have two states, CLEAR and RUN.
REQ-019 In CLEAR: each clock, write all-zero to array[cnt]; cnt increments 0..DEPTH-1; after writing DEPTH-1, go to RUN with cnt = 0.
REQ-020 busy SHALL equal 1 exactly while in CLEAR. After reset release, busy stays high for exactly DEPTH rising edges.
REQ-021 clr sampled 1 in RUN -> CLEAR on next edge with cnt = 0. clr sampled 1 in CLEAR -> cnt restarts at 0.
REQ-022 In RUN, we=1: at the edge, for each i with wbe[i]=1, write byte i of data_in to array[waddr]; bytes with wbe[i]=0 are unchanged.
REQ-023 In RUN, re=1 at edge T: data_out = array[raddr] and rvalid = 1 after T. This is one-cycle read latency.
REQ-024 rvalid SHALL be 0 after any edge where re was not accepted; data_out holds its last value.
REQ-025 Collision (we=1, re=1, waddr=raddr, RUN): RDW_READ_FIRST returns the pre-write word. RDW_WRITE_FIRST returns the byte-merged post-write word.
REQ-026 Reads and writes to different addresses in the same cycle SHALL both complete.
REQ-027 we or re in CLEAR: the access is ignored (no array change, rvalid=0), and drop = 1 for the following cycle.
REQ-028 Addresses wrap naturally at DEPTH; there are no out-of-range addresses.

Reset
REQ-029 rstn low SHALL immediately force state=CLEAR, cnt=0, data_out=0, rvalid=0, busy=1, drop=0.
REQ-030 The array is not reset directly; zeroing is done by the CLEAR sweep after rstn rises.
REQ-031 Reset asserted mid-sweep or mid-access SHALL abandon that operation; the sweep restarts from 0 on release.

Structure
REQ-032 RDW_READ_FIRST, RDW_WRITE_FIRST and the state encoding SHALL live in shared package ram_pkg.
REQ-033 The CLEAR/RUN FSM and counter SHALL be sub-module ram_clr_seq (outputs busy, clr_we, clr_addr). The array, ports and collision logic stay in ram_dp_param.

Verification
REQ-034 Release reset and sample for 16 edges (defaults) -> busy=1 for exactly 16 edges. Then read addr 0..15 -> all 8'h00, rvalid high one cycle per read.
REQ-035 Write addr 2 = AA (wbe=1), then read addr 2 -> data_out=AA one cycle after re.
REQ-036 DATA_WIDTH=32: write 0x11223344 to addr 3, then write 0xFFFFFFFF with wbe=4'b0101 -> read addr 3 = 0x11FF33FF.
REQ-037 Collision at addr 5: old 0x00, write FF -> read returns 00 (READ_FIRST) or FF (WRITE_FIRST). A second read returns FF in both modes.
REQ-038 Pulse clr in RUN, then issue we at addr 10 on the next cycle -> drop=1, busy=1 for 16 edges, addr 10 reads 00 afterwards.
REQ-039 Assert rstn low at sweep count 7 for 2 cycles -> outputs reset asynchronously and busy lasts a full 16 edges after release.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared collision-mode and FSM-state definitions for ram_dp_param
package ram_pkg;
  typedef enum logic {RDW_READ_FIRST = 1'b0, RDW_WRITE_FIRST = 1'b1} rdw_mode_e;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
endpackage

// File: rtl/ram_clr_seq.sv
// ram_clr_seq: CLEAR/RUN sequencer that sweeps zeros through every array address
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
)(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);
  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  last;
  assign last = &cnt_q;
  // leave CLEAR after the top address unless clr restarts the sweep; clr in RUN starts a new sweep
  always_comb begin
    state_d = (state_q == ST_CLEAR) ? ((last && !clr) ? ST_RUN : ST_CLEAR) : (clr ? ST_CLEAR : ST_RUN);
    cnt_d   = (state_q == ST_CLEAR && !clr && !last) ? cnt_q + 1'b1 : '0;
  end
  // state and sweep counter, forced back to the start of a sweep by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy     = (state_q == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt_q;
endmodule

// File: rtl/ram_dp_param.sv
// ram_dp_param: dual-port byte-enabled RAM with clear sweep and selectable read-during-write policy
module ram_dp_param
  import ram_pkg::*;
#(
  parameter int        ADDR_WIDTH = 4,
  parameter int        DATA_WIDTH = 8,
  parameter rdw_mode_e RDW_MODE   = RDW_READ_FIRST
)(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rvalid,
  output logic                    busy,
  output logic                    drop
);
  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH/8;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] wr_word, rd_word;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rvalid_q, rvalid_d, drop_q, drop_d;
  ram_clr_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_seq (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );
  assign wr_acc = we & ~busy;
  assign rd_acc = re & ~busy;
  // overlay the enabled bytes of the incoming write on the stored word
  always_comb begin
    wr_word = mem[waddr];
    for (int b = 0; b < NBYTES; b++) wr_word[8*b +: 8] = wbe[b] ? data_in[8*b +: 8] : wr_word[8*b +: 8];
  end
  assign rd_word = (RDW_MODE == RDW_WRITE_FIRST && wr_acc && waddr == raddr) ? wr_word : mem[raddr];
  // array has no reset: the sweep owns the write port while busy
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_addr] <= '0;
    else if (wr_acc) mem[waddr] <= wr_word;
  end
  // read data holds unless a read is accepted; refused accesses raise drop for one cycle
  always_comb begin
    data_out_d = rd_acc ? rd_word : data_out_q;
    rvalid_d   = rd_acc;
    drop_d     = (we | re) & busy;
  end
  // registered read port and status flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out_q <= '0;
      rvalid_q   <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rvalid_q   <= rvalid_d;
      drop_q     <= drop_d;
    end
  end
  assign data_out = data_out_q;
  assign rvalid   = rvalid_q;
  assign drop     = drop_q;
endmodule

// File: tb/tb_ram_dp_param.sv
// tb_ram_dp_param: scoreboard bench for ram_dp_param with 32-bit words
module tb_ram_dp_param;
  import ram_pkg::*;
  localparam int        AW  = 4;
  localparam int        DW  = 32;
  localparam int        NB  = DW/8;
  localparam int        DEP = 2**AW;
  localparam rdw_mode_e RDW = RDW_READ_FIRST;
  logic          clk = 1'b0;
  logic          rstn, clr, we, re;
  logic [AW-1:0] waddr, raddr;
  logic [NB-1:0] wbe;
  logic [DW-1:0] data_in, data_out;
  logic          rvalid, busy, drop;
  logic [DW-1:0] mdl [DEP];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_dout;
  int            mb;
  int            n_checks = 0;
  int            n_errors = 0;
  ram_dp_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RDW_MODE(RDW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .we       (we),
    .waddr    (waddr),
    .wbe      (wbe),
    .data_in  (data_in),
    .re       (re),
    .raddr    (raddr),
    .data_out (data_out),
    .rvalid   (rvalid),
    .busy     (busy),
    .drop     (drop)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic w, input logic [AW-1:0] wa, input logic [NB-1:0] be,
                      input logic [DW-1:0] d, input logic r, input logic [AW-1:0] ra, input logic c);
    logic          exp_rv, exp_drop;
    logic [DW-1:0] merged;
    we = w; waddr = wa; wbe = be; data_in = d; re = r; raddr = ra; clr = c;
    exp_rv = 1'b0;
    exp_drop = 1'b0;
    if (mb > 0) begin
      exp_drop = w | r;
      mb = c ? DEP : mb - 1;
      if (mb == 0) for (int i = 0; i < DEP; i++) mdl[i] = '0;
    end else begin
      merged = mdl[wa];
      for (int b = 0; b < NB; b++) if (be[b]) merged[8*b +: 8] = d[8*b +: 8];
      if (r) begin
        exp_rv = 1'b1;
        exp_q.push_back((RDW == RDW_WRITE_FIRST && w && wa == ra) ? merged : mdl[ra]);
      end
      if (w) mdl[wa] = merged;
      if (c) mb = DEP;
    end
    @(posedge clk);
    @(negedge clk);
    check("busy", busy, (mb > 0));
    check("drop", drop, exp_drop);
    check("rvalid", rvalid, exp_rv);
    if (exp_rv && exp_q.size() > 0) exp_dout = exp_q.pop_front();
    check($sformatf("data_out r%0d", ra), data_out, exp_dout);
  endtask
  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask
  task automatic rd(input int a);
    step(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
  endtask
  task automatic do_reset();
    we = 0; re = 0; clr = 0; wbe = '0; waddr = '0; raddr = '0; data_in = '0;
    #2 rstn = 1'b0;
    #1;
    check("rst_data_out", data_out, '0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_drop", drop, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    mb = DEP;
    exp_q.delete();
    exp_dout = '0;
  endtask
  initial begin
    rstn = 1'b1;
    mb = DEP;
    exp_dout = '0;
    for (int i = 0; i < DEP; i++) mdl[i] = $urandom;
    @(negedge clk);
    do_reset();
    check("busy_release", busy, 1'b1);
    for (int i = 0; i < DEP; i++) idle();
    for (int i = 0; i < DEP; i++) rd(i);
    idle();
    step(1'b1, 4'd2, 4'h1, 32'h000000AA, 1'b0, '0, 1'b0);
    rd(2);
    check("byte0_write", data_out, 32'h000000AA);
    idle();
    step(1'b1, 4'd3, 4'hF, 32'h11223344, 1'b0, '0, 1'b0);
    step(1'b1, 4'd3, 4'b0101, 32'hFFFFFFFF, 1'b0, '0, 1'b0);
    rd(3);
    check("byte_merge", data_out, 32'h11FF33FF);
    step(1'b1, 4'd5, 4'hF, 32'h000000FF, 1'b1, 4'd5, 1'b0);
    check("collision", data_out, (RDW == RDW_WRITE_FIRST) ? 32'h000000FF : 32'h0);
    rd(5);
    check("collision_reread", data_out, 32'h000000FF);
    step(1'b1, 4'd6, 4'hF, 32'h12345678, 1'b1, 4'd2, 1'b0);
    rd(6);
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    step(1'b1, 4'd10, 4'hF, 32'h00000077, 1'b0, '0, 1'b0);
    check("drop_on_we", drop, 1'b1);
    for (int i = 0; i < DEP - 1; i++) idle();
    rd(10);
    rd(3);
    step(1'b1, 4'd4, 4'hF, 32'h5A5A5A5A, 1'b0, '0, 1'b0);
    rd(4);
    idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 7; i++) idle();
    do_reset();
    for (int i = 0; i < DEP; i++) begin
      if (i == 4) step(1'b0, '0, '0, '0, 1'b1, 4'd4, 1'b0);
      else idle();
    end
    rd(4);
    rd(6);
    step(1'b1, 4'd15, 4'b1000, 32'hC3000000, 1'b1, 4'd15, 1'b0);
    rd(15);
    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
